instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage directly upstream of the control unit: holds the program counter, reads 16-bit instruction words from instruction memory over a ready/strobe handshake, and presents them as `IR` with a valid/ack handshake to the control unit. The control unit sends back branch and jump redirects in the same ack cycle. Redirects use the Mano-style branch offset `AD = {IR[8:6], IR[2:0]}`, sign-extended, applied to the already-incremented PC.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `OFF_W`, 6, width of the branch offset field `AD`
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`
- `mem_addr`  out  16  instruction address, equal to PC
- `mem_rd`  out  1  read strobe; held high until `mem_ready`
- `mem_rdata`  in  16  instruction word; valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the read this cycle
- `IR`  out  16  current instruction word to the control unit
- `ir_valid`  out  1  `IR` holds an unconsumed instruction
- `ir_ack`  in  1  control unit has consumed `IR`; redirect inputs sampled in the same cycle
- `br_take`  in  1  take branch: PC ← PC + sext(`br_off`)
- `br_off`  in  OFF_W  signed branch offset (`AD`)
- `jmp_take`  in  1  take jump: PC ← `jmp_addr`
- `jmp_addr`  in  16  absolute jump target (R[SA])
- `halt`  in  1  stop fetching after the current instruction is acked
- `pc`  out  16  current PC, for the status register and debug

## Operation
- The FSM has three states: FETCH, HOLD, HALT.
- **FETCH**
  - `mem_rd`=1, `mem_addr`=PC.
  - On `mem_ready`=1: IR ← `mem_rdata`, PC ← PC+1, then go to HOLD.
  - Otherwise stay in FETCH with address and strobe stable.
- **HOLD**
  - `ir_valid`=1, `mem_rd`=0, `IR` stable.
  - Stay in HOLD until `ir_ack`=1.
  - On `ir_ack`, the PC update and next state are decided by priority:
    - `jmp_take`: PC ← `jmp_addr`.
    - else `br_take`: PC ← PC + sext(`br_off`).
    - else PC unchanged.
    - Next state is HALT if `halt`=1, otherwise FETCH.
- **HALT**
  - `mem_rd`=0, `ir_valid`=0, PC frozen.
  - Left only by reset.
- **Arithmetic:** all PC arithmetic is modulo 2^16. PC 16'hFFFF + 1 wraps to 16'h0000. Branch offset range is −32..+31.
- **Ignored inputs:**
  - Redirect and `halt` inputs are ignored unless in HOLD with `ir_ack`=1.
  - `mem_ready` is ignored outside FETCH.
  - `ir_ack` is ignored outside HOLD.
- **Simultaneous events:** `jmp_take` and `br_take` both high → jump wins. `halt` combined with a redirect → PC is updated, then the block enters HALT.

## Timing
- **Reset** (`reset`=0 at an edge):
  - state ← FETCH, PC ← RESET_PC, IR ← 16'h0000.
  - While `reset`=0: `mem_rd`=0 and `ir_valid`=0 (gated).
  - First `mem_rd`=1 is in the first cycle with `reset`=1.
- **Reset mid-operation:** an outstanding fetch is abandoned and a `mem_ready` in the reset cycle is ignored. A held `IR` is dropped, with no ack required.
- **Latency:**
  - `mem_ready` in cycle n → `IR` and `ir_valid`=1 in cycle n+1.
  - `ir_ack` in cycle m → `mem_rd`=1 with the redirected `mem_addr` in cycle m+1.
- **Throughput:** with zero-wait memory (`mem_ready`=1 whenever `mem_rd`=1) and an immediate ack, one instruction every 2 cycles.
- **Output timing:**
  - `mem_rd`, `ir_valid`, `mem_addr`, `pc` are decoded from registered state/PC, with no combinational path from inputs.
  - `IR` changes only on the FETCH→HOLD edge or on reset.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch state enum (FETCH, HOLD, HALT);
  - the word width 16 and `OFF_W`;
  - field-slice constants for `AD` (IR[8:6], IR[2:0]);
  - opcode constants shared with the control unit (e.g. BRN = 7'b1011110 family).
- One natural sub-module: `pc_next`, the combinational next-PC mux/adder covering increment, sign-extended branch add, jump select and priority. The FSM and registers stay in the top.

## Test plan
- **Reset and first fetch:** hold `reset`=0 for 2 cycles, then release. Require `mem_rd`=0 during reset; `mem_rd`=1 and `mem_addr`=16'h0000 in the first cycle after release; `IR`=16'h0000.
- **Wait states:** `mem_ready` low 3 cycles, then high with `mem_rdata`=16'h5D1A. Require `mem_addr` stable for all 4 cycles, then `IR`=16'h5D1A, `ir_valid`=1 and `pc`=16'h0001 next cycle.
- **Branch:** instruction at 16'h0010, ack with `br_take`=1 and `br_off`=6'b111110 (−2). Require next `mem_addr`=16'h000F. With `br_off`=6'd5, require 16'h0016.
- **Jump vs branch priority:** ack with `jmp_take`=1, `jmp_addr`=16'h1234, `br_take`=1. Require next `mem_addr`=16'h1234.
- **Wrap and stall:** PC=16'hFFFF fetch. Require `pc`=16'h0000 after capture. Delay `ir_ack` 5 cycles and require `IR` stable with `mem_rd`=0 throughout.
- **Halt and reset mid-fetch:** ack with `halt`=1. Require `mem_rd`=0 and `ir_valid`=0 indefinitely. Then assert `reset` during a FETCH with `mem_ready`=1. Require `IR` unchanged (16'h0000) and `pc`=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath widths, the AD
// branch-offset field layout and opcodes shared with the control unit.
package cpu_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned CPU_OFF_W = 6;

  // AD = {IR[8:6], IR[2:0]}
  localparam int unsigned AD_HI_MSB = 8;
  localparam int unsigned AD_HI_LSB = 6;
  localparam int unsigned AD_LO_MSB = 2;
  localparam int unsigned AD_LO_LSB = 0;

  // Opcode family constants (IR[15:9]) decoded by the control unit
  localparam logic [6:0] OP_BRZ = 7'b1011100;
  localparam logic [6:0] OP_BRN = 7'b1011110;
  localparam logic [6:0] OP_JMP = 7'b1110000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Extract the AD branch-offset field from an instruction word
  function automatic logic [CPU_OFF_W-1:0] ad_field(input logic [WORD_W-1:0] ir);
    return {ir[AD_HI_MSB:AD_HI_LSB], ir[AD_LO_MSB:AD_LO_LSB]};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: increment after a fetch, or on ack the
// jump target / sign-extended branch / unchanged PC, jump having priority.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned OFF_W = CPU_OFF_W
) (
  input  logic [WORD_W-1:0] pc,
  input  logic              fetch_done,
  input  logic              redirect_en,
  input  logic              jmp_take,
  input  logic [WORD_W-1:0] jmp_addr,
  input  logic              br_take,
  input  logic [OFF_W-1:0]  br_off,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] br_ext;

  // Priority mux: fetch increment, then jump over branch on redirect
  always_comb begin
    br_ext  = {{(WORD_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    next_pc = pc;
    if (fetch_done) begin
      next_pc = pc + WORD_W'(1);
    end else if (redirect_en) begin
      if (jmp_take) begin
        next_pc = jmp_addr;
      end else if (br_take) begin
        next_pc = pc + br_ext;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake and IR hand-off to the
// control unit, with branch/jump redirects accepted in the ack cycle.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned OFF_W    = CPU_OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic [15:0]       mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       IR,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              br_take,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              jmp_take,
  input  logic [15:0]       jmp_addr,
  input  logic              halt,
  output logic [15:0]       pc
);

  fetch_state_t state;
  logic [15:0]  pc_q;
  logic [15:0]  ir_q;
  logic [15:0]  npc;
  logic         fetch_done;
  logic         redirect_en;

  assign fetch_done  = (state == FETCH) && mem_ready;
  assign redirect_en = (state == HOLD) && ir_ack;

  pc_next #(
    .OFF_W(OFF_W)
  ) u_pc_next (
    .pc         (pc_q),
    .fetch_done (fetch_done),
    .redirect_en(redirect_en),
    .jmp_take   (jmp_take),
    .jmp_addr   (jmp_addr),
    .br_take    (br_take),
    .br_off     (br_off),
    .next_pc    (npc)
  );

  // Fetch FSM with PC and IR registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir_q  <= mem_rdata;
            pc_q  <= npc;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ack) begin
            pc_q  <= npc;
            state <= halt ? HALT : FETCH;
          end
        end
        HALT: begin
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are gated while reset is held so nothing is requested or offered
  assign mem_rd   = reset && (state == FETCH);
  assign ir_valid = reset && (state == HOLD);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign IR       = ir_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, a transaction-level model
// checked every cycle, and literal expectations at key points.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] IR;
  logic        ir_valid;
  logic        ir_ack = 1'b0;
  logic        br_take = 1'b0;
  logic [5:0]  br_off = '0;
  logic        jmp_take = 1'b0;
  logic [15:0] jmp_addr = '0;
  logic        halt = 1'b0;
  logic [15:0] pc;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit #(
    .RESET_PC(16'h0000),
    .OFF_W   (6)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .IR       (IR),
    .ir_valid (ir_valid),
    .ir_ack   (ir_ack),
    .br_take  (br_take),
    .br_off   (br_off),
    .jmp_take (jmp_take),
    .jmp_addr (jmp_addr),
    .halt     (halt),
    .pc       (pc)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction is either awaiting fetch, held awaiting ack, or
  // the unit has stopped; PC advances by the architectural rules.
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  bit          m_have;
  bit          m_stopped;
  bit          m_known = 0;

  always @(posedge clock) begin
    if (!reset) begin
      m_pc = 16'h0000; m_ir = 16'h0000; m_have = 0; m_stopped = 0; m_known = 1;
    end else if (m_known && !m_stopped) begin
      if (!m_have) begin
        if (mem_ready) begin
          m_ir = mem_rdata; m_pc = m_pc + 16'd1; m_have = 1;
        end
      end else if (ir_ack) begin
        if (jmp_take) m_pc = jmp_addr;
        else if (br_take) m_pc = m_pc + {{10{br_off[5]}}, br_off};
        m_have = 0;
        m_stopped = halt;
      end
    end
  end

  always @(negedge clock) begin
    if (m_known) begin
      check("mdl_mem_rd", {15'b0, mem_rd}, {15'b0, reset && !m_stopped && !m_have});
      check("mdl_ir_valid", {15'b0, ir_valid}, {15'b0, reset && m_have});
      check("mdl_mem_addr", mem_addr, m_pc);
      check("mdl_pc", pc, m_pc);
      check("mdl_IR", IR, m_ir);
    end
  end

  // One clock edge; inputs change 2 time units after the edge
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic fetch(input logic [15:0] data);
    mem_ready = 1'b1; mem_rdata = data;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic ack(input logic j, input logic [15:0] ja, input logic b,
                     input logic [5:0] off, input logic h);
    ir_ack = 1'b1; jmp_take = j; jmp_addr = ja; br_take = b; br_off = off; halt = h;
    step();
    ir_ack = 1'b0; jmp_take = 1'b0; br_take = 1'b0; halt = 1'b0;
  endtask

  initial begin
    // Reset and first fetch
    reset = 1'b0;
    step();
    check("rst_mem_rd", {15'b0, mem_rd}, 16'd0);
    step();
    check("rst_mem_rd2", {15'b0, mem_rd}, 16'd0);
    check("rst_ir_valid", {15'b0, ir_valid}, 16'd0);
    reset = 1'b1;
    #1;
    check("first_mem_rd", {15'b0, mem_rd}, 16'd1);
    check("first_addr", mem_addr, 16'h0000);
    check("first_IR", IR, 16'h0000);

    // Wait states
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", mem_addr, 16'h0000);
      check("wait_rd", {15'b0, mem_rd}, 16'd1);
    end
    fetch(16'h5D1A);
    check("ws_IR", IR, 16'h5D1A);
    check("ws_valid", {15'b0, ir_valid}, 16'd1);
    check("ws_pc", pc, 16'h0001);

    // Branch -2 from instruction at 0x0010
    ack(1'b1, 16'h0010, 1'b0, 6'd0, 1'b0);
    check("jmp10_addr", mem_addr, 16'h0010);
    fetch(16'h1111);
    check("pc_after_10", pc, 16'h0011);
    ack(1'b0, 16'h0000, 1'b1, 6'b111110, 1'b0);
    check("br_neg2", mem_addr, 16'h000F);
    check("br_neg2_rd", {15'b0, mem_rd}, 16'd1);
    fetch(16'h2222);
    ack(1'b1, 16'h0010, 1'b0, 6'd0, 1'b0);
    fetch(16'h3333);
    ack(1'b0, 16'h0000, 1'b1, 6'd5, 1'b0);
    check("br_pos5", mem_addr, 16'h0016);

    // Jump beats branch
    fetch(16'h4444);
    ack(1'b1, 16'h1234, 1'b1, 6'd5, 1'b0);
    check("jmp_prio", mem_addr, 16'h1234);

    // Most negative / positive offsets
    fetch(16'h4545);
    ack(1'b0, 16'h0000, 1'b1, 6'b100000, 1'b0);
    check("br_min", mem_addr, 16'h1215);
    fetch(16'h4646);
    ack(1'b0, 16'h0000, 1'b1, 6'b011111, 1'b0);
    check("br_max", mem_addr, 16'h1235);

    // Wrap and stall; ready/rdata noise must be ignored while held
    fetch(16'h4747);
    ack(1'b1, 16'hFFFF, 1'b0, 6'd0, 1'b0);
    fetch(16'hA5A5);
    check("wrap_pc", pc, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; mem_rdata = 16'h0F0F + 16'(i);
      step();
      check("stall_IR", IR, 16'hA5A5);
      check("stall_rd", {15'b0, mem_rd}, 16'd0);
    end
    mem_ready = 1'b0;
    ack(1'b0, 16'h0000, 1'b0, 6'd0, 1'b0);
    check("no_redirect", mem_addr, 16'h0000);

    // Back-to-back: one instruction every 2 cycles
    mem_ready = 1'b1; ir_ack = 1'b1; mem_rdata = 16'h7777;
    for (int i = 0; i < 6; i++) step();
    mem_ready = 1'b0; ir_ack = 1'b0;
    check("thru_pc", pc, 16'h0003);

    // Halt combined with a branch
    fetch(16'h8888);
    ack(1'b0, 16'h0000, 1'b1, 6'd3, 1'b1);
    check("halt_pc", pc, 16'h0007);
    mem_ready = 1'b1; ir_ack = 1'b1; jmp_take = 1'b1; jmp_addr = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_rd", {15'b0, mem_rd}, 16'd0);
      check("halt_valid", {15'b0, ir_valid}, 16'd0);
      check("halt_pc_frozen", pc, 16'h0007);
    end
    mem_ready = 1'b0; ir_ack = 1'b0; jmp_take = 1'b0;

    // Reset out of HALT, then reset during FETCH with mem_ready high
    reset = 1'b0;
    step();
    check("rst2_IR", IR, 16'h0000);
    reset = 1'b1;
    step();
    check("rst2_rd", {15'b0, mem_rd}, 16'd1);
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    check("rstf_IR", IR, 16'h0000);
    check("rstf_pc", pc, 16'h0000);
    check("rstf_rd", {15'b0, mem_rd}, 16'd0);
    mem_ready = 1'b0; reset = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
